// File: rtl/cpu_mmu_csr_ctl.sv
// +------------------------------------------------------------------------+
// | cpu_mmu_csr_ctl                                                        |
// | Cache status register control: enable bit and 1024-entry tag sweep.    |
// | Rev 1.0                                                                |
// +------------------------------------------------------------------------+
`default_nettype none

module cpu_mmu_csr_ctl (
  input  logic       sysclk,
  input  logic       sys_rst_n,
  input  logic       LCSR_n,
  input  logic [1:0] IDB_IN,
  input  logic       CUP_STRAP,
  input  logic       CBUSY,
  output logic       CUP,
  output logic       CON,
  output logic       STP,
  output logic [9:0] CA,
  output logic       CWE_n,
  output logic       CCLR_DONE
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  localparam logic [9:0] c_LAST_ADDR = 10'd1023;

  state_t     r_state;
  state_t     w_state_nxt;
  logic [9:0] r_cnt;
  logic [9:0] w_cnt_nxt;
  logic       r_con;
  logic       w_stp;
  logic       w_clr_req;

  assign w_clr_req = ~LCSR_n & IDB_IN[1] & CUP_STRAP;

  always_ff @(posedge sysclk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= 10'd0;
      r_con   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (!LCSR_n) begin
        r_con <= IDB_IN[0];
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_stp       = 1'b0;
    CA          = 10'd0;
    CWE_n       = 1'b1;
    CCLR_DONE   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_clr_req) begin
          w_state_nxt = ST_CLEAR;
          w_cnt_nxt   = 10'd0;
        end
      end
      ST_CLEAR: begin
        w_stp = 1'b1;
        CA    = r_cnt;
        CWE_n = CBUSY;
        // A busy cache RAM stalls the sweep in place, including on the last address.
        if (!CBUSY) begin
          w_cnt_nxt = r_cnt + 10'd1;
          if (r_cnt == c_LAST_ADDR) begin
            w_state_nxt = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        CCLR_DONE   = 1'b1;
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  assign STP = w_stp;
  assign CUP = CUP_STRAP;
  assign CON = r_con & CUP_STRAP & ~w_stp;

endmodule

`default_nettype wire

// File: tb/tb_cpu_mmu_csr_ctl.sv
// +------------------------------------------------------------------------+
// | tb_cpu_mmu_csr_ctl                                                     |
// | Vector table, directed sweeps and random run against a reference model.|
// | Rev 1.0                                                                |
// +------------------------------------------------------------------------+
`default_nettype none

module tb_cpu_mmu_csr_ctl;

  logic       sysclk = 1'b0;
  logic       sys_rst_n;
  logic       LCSR_n;
  logic [1:0] IDB_IN;
  logic       CUP_STRAP;
  logic       CBUSY;
  logic       CUP;
  logic       CON;
  logic       STP;
  logic [9:0] CA;
  logic       CWE_n;
  logic       CCLR_DONE;

  always #5 sysclk = ~sysclk;

  cpu_mmu_csr_ctl dut (
    .sysclk    (sysclk),
    .sys_rst_n (sys_rst_n),
    .LCSR_n    (LCSR_n),
    .IDB_IN    (IDB_IN),
    .CUP_STRAP (CUP_STRAP),
    .CBUSY     (CBUSY),
    .CUP       (CUP),
    .CON       (CON),
    .STP       (STP),
    .CA        (CA),
    .CWE_n     (CWE_n),
    .CCLR_DONE (CCLR_DONE)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: how many tag addresses have been cleared in the current sweep.
  bit m_con;
  bit m_active;
  bit m_done;
  int m_written;
  int seen [1024];

  typedef struct {
    bit         l;
    logic [1:0] d;
    bit         s;
    bit         b;
    bit         e_cup;
    bit         e_con;
    bit         e_stp;
    int         e_ca;
    bit         e_cwe;
    bit         e_done;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_con = 0; m_active = 0; m_done = 0; m_written = 0;
  endtask

  task automatic clear_seen();
    for (int i = 0; i < 1024; i++) seen[i] = 0;
  endtask

  task automatic model_update();
    bit done_nxt;
    done_nxt = 0;
    if (m_active) begin
      if (!CBUSY) begin
        seen[m_written]++;
        m_written++;
        if (m_written == 1024) begin
          m_active  = 0;
          m_written = 0;
          done_nxt  = 1;
        end
      end
    end else if (!m_done && !LCSR_n && IDB_IN[1] && CUP_STRAP) begin
      m_active  = 1;
      m_written = 0;
    end
    m_done = done_nxt;
    if (!LCSR_n) m_con = IDB_IN[0];
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".CUP"},       32'(CUP),       32'(CUP_STRAP));
    chk({tag, ".CON"},       32'(CON),       32'(m_con && CUP_STRAP && !m_active));
    chk({tag, ".STP"},       32'(STP),       32'(m_active));
    chk({tag, ".CA"},        32'(CA),        m_active ? 32'(m_written) : 32'd0);
    chk({tag, ".CWE_n"},     32'(CWE_n),     m_active ? 32'(CBUSY) : 32'd1);
    chk({tag, ".CCLR_DONE"}, 32'(CCLR_DONE), 32'(m_done));
  endtask

  task automatic drive(input bit l, input logic [1:0] d, input bit s, input bit b);
    @(negedge sysclk);
    LCSR_n = l; IDB_IN = d; CUP_STRAP = s; CBUSY = b;
    #2;
  endtask

  task automatic tick();
    @(posedge sysclk);
    model_update();
  endtask

  task automatic do_reset();
    @(negedge sysclk);
    LCSR_n = 1; IDB_IN = 2'b00; CBUSY = 0;
    sys_rst_n = 0;
    #1;
    model_reset();
    check_model("reset");
    @(negedge sysclk);
    sys_rst_n = 1;
  endtask

  // Runs an already-started sweep to its done pulse, optionally stalling and re-requesting.
  task automatic run_sweep(input int stall_at, input int stall_len,
                           input int rq1_at, input logic [1:0] rq1,
                           input int rq2_at, input logic [1:0] rq2,
                           input bit poke_done,
                           output int stp_cyc, output int lows, output int dones);
    int  stalled;
    bit  r1, r2, fin;
    bit  l, b;
    logic [1:0] d;
    stalled = 0; r1 = 0; r2 = 0; fin = 0;
    stp_cyc = 0; lows = 0; dones = 0;
    for (int cyc = 0; cyc < 1300; cyc++) begin
      l = 1; d = 2'b00; b = 0;
      if (m_active && m_written == stall_at && stalled < stall_len) begin
        b = 1; stalled++;
      end
      if (m_active && m_written == rq1_at && !r1) begin
        l = 0; d = rq1; r1 = 1;
      end else if (m_active && m_written == rq2_at && !r2) begin
        l = 0; d = rq2; r2 = 1;
      end
      if (m_done && poke_done) begin
        l = 0; d = 2'b11;
      end
      drive(l, d, CUP_STRAP, b);
      check_model("sweep");
      if (STP) stp_cyc++;
      if (!CWE_n) lows++;
      if (CCLR_DONE) dones++;
      if (m_done) begin
        tick();
        fin = 1;
        break;
      end
      tick();
    end
    if (!fin) chk("sweep_timeout", 32'd0, 32'd1);
  endtask

  function automatic int addr_faults();
    int n;
    n = 0;
    for (int i = 0; i < 1024; i++) if (seen[i] != 1) n++;
    return n;
  endfunction

  vec_t vt [14];
  int   sc, lw, dn;

  initial begin
    vt[0]  = '{1, 2'b00, 1, 0,  1, 0, 0, 0, 1, 0};
    vt[1]  = '{0, 2'b01, 1, 0,  1, 0, 0, 0, 1, 0};
    vt[2]  = '{1, 2'b00, 1, 0,  1, 1, 0, 0, 1, 0};
    vt[3]  = '{1, 2'b00, 0, 0,  0, 0, 0, 0, 1, 0};
    vt[4]  = '{0, 2'b11, 0, 0,  0, 0, 0, 0, 1, 0};
    vt[5]  = '{1, 2'b00, 0, 1,  0, 0, 0, 0, 1, 0};
    vt[6]  = '{1, 2'b00, 1, 0,  1, 1, 0, 0, 1, 0};
    vt[7]  = '{0, 2'b10, 1, 0,  1, 1, 0, 0, 1, 0};
    vt[8]  = '{1, 2'b00, 1, 1,  1, 0, 1, 0, 1, 0};
    vt[9]  = '{1, 2'b00, 1, 0,  1, 0, 1, 0, 0, 0};
    vt[10] = '{1, 2'b00, 1, 0,  1, 0, 1, 1, 0, 0};
    vt[11] = '{0, 2'b01, 1, 1,  1, 0, 1, 2, 1, 0};
    vt[12] = '{1, 2'b00, 1, 0,  1, 0, 1, 2, 0, 0};
    vt[13] = '{1, 2'b00, 0, 0,  0, 0, 1, 3, 0, 0};

    sys_rst_n = 0; LCSR_n = 1; IDB_IN = 2'b00; CUP_STRAP = 1; CBUSY = 0;
    model_reset();
    clear_seen();
    #3;
    check_model("por");
    @(negedge sysclk);
    sys_rst_n = 1;

    // Table-driven short sequences: enable, strap masking, ignored clear, sweep start.
    for (int i = 0; i < 14; i++) begin
      drive(vt[i].l, vt[i].d, vt[i].s, vt[i].b);
      chk($sformatf("vec%0d.CUP", i),       32'(CUP),       32'(vt[i].e_cup));
      chk($sformatf("vec%0d.CON", i),       32'(CON),       32'(vt[i].e_con));
      chk($sformatf("vec%0d.STP", i),       32'(STP),       32'(vt[i].e_stp));
      chk($sformatf("vec%0d.CA", i),        32'(CA),        32'(vt[i].e_ca));
      chk($sformatf("vec%0d.CWE_n", i),     32'(CWE_n),     32'(vt[i].e_cwe));
      chk($sformatf("vec%0d.CCLR_DONE", i), 32'(CCLR_DONE), 32'(vt[i].e_done));
      tick();
    end
    do_reset();

    // Full sweep, with a clear request poked during the done cycle.
    clear_seen();
    drive(0, 2'b11, 1, 0); check_model("full_start"); tick();
    run_sweep(-1, 0, -1, 2'b00, -1, 2'b00, 1, sc, lw, dn);
    chk("full.stp_cycles", 32'(sc), 32'd1024);
    chk("full.cwe_lows",   32'(lw), 32'd1024);
    chk("full.done_pulses", 32'(dn), 32'd1);
    chk("full.addr_faults", 32'(addr_faults()), 32'd0);
    drive(1, 2'b00, 1, 0); check_model("full_after");
    chk("full.con_after", 32'(CON), 32'd1);
    chk("full.no_restart", 32'(STP), 32'd0);
    tick();

    // Stall of 5 cycles at address 500.
    clear_seen();
    drive(0, 2'b11, 1, 0); check_model("stall_start"); tick();
    run_sweep(500, 5, -1, 2'b00, -1, 2'b00, 0, sc, lw, dn);
    chk("stall.stp_cycles", 32'(sc), 32'd1029);
    chk("stall.cwe_lows",   32'(lw), 32'd1024);
    chk("stall.addr_faults", 32'(addr_faults()), 32'd0);

    // Stall on the final address.
    clear_seen();
    drive(0, 2'b11, 1, 0); check_model("last_start"); tick();
    run_sweep(1023, 3, -1, 2'b00, -1, 2'b00, 0, sc, lw, dn);
    chk("last.stp_cycles", 32'(sc), 32'd1027);
    chk("last.addr_faults", 32'(addr_faults()), 32'd0);

    // Re-requests during the sweep do not extend it; the final write disables the cache.
    clear_seen();
    drive(0, 2'b11, 1, 0); check_model("rq_start"); tick();
    run_sweep(-1, 0, 200, 2'b10, 400, 2'b00, 0, sc, lw, dn);
    chk("rq.stp_cycles", 32'(sc), 32'd1024);
    chk("rq.done_pulses", 32'(dn), 32'd1);
    drive(1, 2'b00, 1, 0); check_model("rq_after");
    chk("rq.con_after", 32'(CON), 32'd0);
    tick();

    // No cache unit: the clear request is ignored entirely.
    lw = 0; sc = 0;
    drive(0, 2'b11, 0, 0); check_model("nocache_req"); tick();
    for (int i = 0; i < 20; i++) begin
      drive(1, 2'b00, 0, 0); check_model("nocache");
      if (STP) sc++;
      if (!CWE_n) lw++;
      tick();
    end
    chk("nocache.stp", 32'(sc), 32'd0);
    chk("nocache.cwe_lows", 32'(lw), 32'd0);
    chk("nocache.CUP", 32'(CUP), 32'd0);

    // Reset mid-sweep at address 300.
    drive(0, 2'b11, 1, 0); check_model("rst_start"); tick();
    for (int i = 0; i < 400 && !(m_active && m_written == 300); i++) begin
      drive(1, 2'b00, 1, 0); check_model("rst_pre"); tick();
    end
    drive(1, 2'b00, 1, 0);
    chk("rst.at_300", 32'(CA), 32'd300);
    sys_rst_n = 0;
    #1;
    model_reset();
    check_model("rst_mid");
    chk("rst.STP", 32'(STP), 32'd0);
    chk("rst.CA", 32'(CA), 32'd0);
    chk("rst.CWE_n", 32'(CWE_n), 32'd1);
    @(negedge sysclk);
    sys_rst_n = 1;
    lw = 0; dn = 0;
    for (int i = 0; i < 20; i++) begin
      drive(1, 2'b00, 1, 0); check_model("rst_post");
      if (!CWE_n) lw++;
      if (CCLR_DONE) dn++;
      tick();
    end
    chk("rst.cwe_lows", 32'(lw), 32'd0);
    chk("rst.done_pulses", 32'(dn), 32'd0);

    // Random traffic, including strap drops mid-sweep.
    begin
      bit s;
      s = 1;
      for (int i = 0; i < 6000; i++) begin
        if ($urandom_range(0, 299) == 0) s = ~s;
        drive($urandom_range(0, 39) != 0, 2'($urandom_range(0, 3)), s,
              $urandom_range(0, 9) < 3);
        check_model("rand");
        tick();
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/cpu_mmu_csr_ctl.md
CPU_MMU_CSR_CTL -- requirements
Module: cpu_mmu_csr_ctl

Interface
REQ-001 The block SHALL have these ports, clock and reset first, in this order:
- sysclk  in  1  system clock; all state changes on the rising edge.
- sys_rst_n  in  1  asynchronous active-low reset.
- LCSR_n  in  1  load cache status register, active low, sampled on sysclk.
- IDB_IN  in  2  write data: bit0 = cache-on request, bit1 = cache-clear request.
- CUP_STRAP  in  1  cache unit present strap, static.
- CBUSY  in  1  cache RAM in use by a memory cycle; the sweep holds while high.
- CUP  out  1  cache unit present; equals CUP_STRAP.
- CON  out  1  effective cache enable.
- STP  out  1  cache clear in progress.
- CA  out  10  cache RAM address during the sweep.
- CWE_n  out  1  cache RAM write enable, active low, writes an invalid tag.
- CCLR_DONE  out  1  one-cycle pulse when the sweep completes.

REQ-002 These outputs feed the cache status register bus buffer: CUP, CON and STP directly, STP as the stop bit.

Function
REQ-003 The block SHALL hold a registered enable bit con_reg, loaded from IDB_IN[0] on any sysclk edge where LCSR_n=0.
REQ-004 CON SHALL equal con_reg AND CUP_STRAP AND NOT STP, evaluated combinationally.
REQ-005 The block SHALL implement a three-state FSM: IDLE, CLEAR and DONE.
REQ-006 IDLE to CLEAR SHALL occur on an edge where LCSR_n=0, IDB_IN[1]=1 and CUP_STRAP=1.
- The 10-bit counter SHALL load 0 on that edge.
- If CUP_STRAP=0, the clear request SHALL be ignored and the FSM SHALL stay in IDLE.
REQ-007 In CLEAR, STP SHALL be 1, CA SHALL equal the counter, and CWE_n SHALL equal CBUSY.
- CWE_n is therefore low only when CBUSY=0.
REQ-008 In CLEAR, the counter SHALL increment by 1 on each edge where CBUSY=0 and SHALL hold on each edge where CBUSY=1.
REQ-009 In CLEAR, when the counter equals 1023 and CBUSY=0, the next state SHALL be DONE.
- The counter SHALL wrap to 0.
- Exactly 1024 write cycles SHALL be issued, one per address 0..1023, each address once.
REQ-010 In DONE, the block SHALL drive STP=0, CWE_n=1 and CCLR_DONE=1 for exactly one cycle, then return to IDLE.
REQ-011 Outside CLEAR, CWE_n SHALL be 1 and CA SHALL be 0.
REQ-012 LCSR_n=0 during CLEAR SHALL update con_reg, SHALL ignore IDB_IN[1], and SHALL NOT restart or extend the sweep.
REQ-013 LCSR_n=0 in DONE with IDB_IN[1]=1 SHALL be ignored: no new sweep.
REQ-014 If CUP_STRAP falls during CLEAR, the sweep SHALL continue to completion, and CON SHALL be 0.
REQ-015 Simultaneous CBUSY=1 and a final address of 1023 SHALL hold in CLEAR until CBUSY=0.

Reset
REQ-016 sys_rst_n=0 SHALL immediately, without waiting for a clock edge, force:
- state = IDLE, con_reg = 0, counter = 0
- CON = 0, STP = 0, CA = 0, CWE_n = 1, CCLR_DONE = 0
REQ-017 Reset asserted mid-sweep SHALL abort the sweep with no further CWE_n pulses and no CCLR_DONE.
REQ-018 After reset deassertion, the block SHALL remain in IDLE until a clear request arrives.

Verification
REQ-019 The bench SHALL cover these directed scenarios:
- Enable: CUP_STRAP=1, one LCSR_n pulse with IDB_IN=01 -> CON=1 on the next edge, STP=0, CWE_n=1 throughout.
- Full sweep: CUP_STRAP=1, IDB_IN=11 pulse, CBUSY=0 -> STP=1 for 1024 cycles, CA=0..1023 ascending, 1024 CWE_n lows, CON=0 during the sweep, then CCLR_DONE=1 for one cycle, then CON=1.
- Stall: during the sweep, CBUSY=1 for 5 cycles at CA=500 -> CA holds 500, CWE_n=1 for those cycles, total sweep length 1029 cycles, no address skipped or repeated.
- No cache: CUP_STRAP=0, IDB_IN=11 pulse -> STP stays 0, CON=0, CUP=0, no CWE_n activity.
- Re-request: IDB_IN=10 pulse at CA=200 -> sweep length unchanged; IDB_IN=00 pulse -> CON=0 after completion.
- Reset mid-sweep: sys_rst_n low at CA=300 -> STP=0, CA=0, CWE_n=1 immediately, no CCLR_DONE.
